// File: rtl/data_mem_unit.sv
// ============================================================================
// Module   : data_mem_unit
// Purpose  : M-stage data memory with byte-lane stores, sign/zero-extending
//            loads, misalignment flag and a small MMIO window (LED, CYC, STAT).
//            Optional cycle counter enabled by defining DMEM_CYCLE_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_unit #(
    parameter int          DEPTH_WORDS = 1024,
    parameter string       INIT_FILE   = "",
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic        mem_rd,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    input  logic [2:0]  funct3,
    output logic [31:0] ReadData,
    output logic [7:0]  leds,
    output logic        misalign
);

    localparam int         AW         = $clog2(DEPTH_WORDS);
    localparam logic [2:0] c_F3_B     = 3'b000;
    localparam logic [2:0] c_F3_H     = 3'b001;
    localparam logic [2:0] c_F3_W     = 3'b010;
    localparam logic [2:0] c_F3_BU    = 3'b100;
    localparam logic [2:0] c_F3_HU    = 3'b101;
    localparam logic [13:0] c_OFF_LED  = 14'd0;
    localparam logic [13:0] c_OFF_CYC  = 14'd1;
    localparam logic [13:0] c_OFF_STAT = 14'd2;

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [7:0]    r_leds;
    logic          r_mis;

    logic          w_is_b, w_is_h, w_is_w, w_mis, w_wr, w_mmio;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata, w_cyc, w_mmio_word, w_word;
    logic [AW-1:0] w_idx;
    logic [13:0]   w_off;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;

    assign w_is_b = (funct3 == c_F3_B) || (funct3 == c_F3_BU);
    assign w_is_h = (funct3 == c_F3_H) || (funct3 == c_F3_HU);
    assign w_is_w = (funct3 == c_F3_W);
    assign w_mis  = (w_is_h && addr[0]) || (w_is_w && (addr[1:0] != 2'b00));
    assign w_wr   = MemWriteM && !w_mis;
    assign w_mmio = (addr[31:16] == MMIO_BASE[31:16]);
    assign w_off  = addr[15:2];
    assign w_idx  = addr[AW+1:2];

    // Store data is replicated across lanes so each enabled lane picks its own byte.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = wr_data;
        if (w_is_b) begin
            w_be    = 4'b0001 << addr[1:0];
            w_wdata = {4{wr_data[7:0]}};
        end else if (w_is_h) begin
            w_be    = addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{wr_data[15:0]}};
        end else if (w_is_w) begin
            w_be    = 4'b1111;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_wr && !w_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    // A misaligned access sets the flag even when a W1C to STAT lands alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_leds <= 8'h00;
            r_mis  <= 1'b0;
        end else begin
            if (w_wr && w_mmio && (w_off == c_OFF_LED) && w_be[0])
                r_leds <= w_wdata[7:0];
            if ((MemWriteM || mem_rd) && w_mis)
                r_mis <= 1'b1;
            else if (w_wr && w_mmio && (w_off == c_OFF_STAT) && w_be[0] && w_wdata[0])
                r_mis <= 1'b0;
        end
    end

`ifdef DMEM_CYCLE_CNT_EN
    logic [31:0] r_cyc;
    always_ff @(posedge clk) begin
        if (reset) r_cyc <= 32'h0;
        else       r_cyc <= r_cyc + 32'h1;
    end
    assign w_cyc = r_cyc;
`else
    assign w_cyc = 32'h0;
`endif

    always_comb begin
        w_mmio_word = 32'h0;
        case (w_off)
            c_OFF_LED:  w_mmio_word = {24'h0, r_leds};
            c_OFF_CYC:  w_mmio_word = w_cyc;
            c_OFF_STAT: w_mmio_word = {31'h0, r_mis};
            default:    w_mmio_word = 32'h0;
        endcase
    end

    assign w_word = w_mmio ? w_mmio_word : r_mem[w_idx];
    assign w_byte = w_word[8*addr[1:0] +: 8];
    assign w_half = addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        ReadData = 32'h0;
        if (!(mem_rd && w_mis)) begin
            case (funct3)
                c_F3_B:  ReadData = {{24{w_byte[7]}}, w_byte};
                c_F3_H:  ReadData = {{16{w_half[15]}}, w_half};
                c_F3_W:  ReadData = w_word;
                c_F3_BU: ReadData = {24'h0, w_byte};
                c_F3_HU: ReadData = {16'h0, w_half};
                default: ReadData = 32'h0;
            endcase
        end
    end

    assign leds     = r_leds;
    assign misalign = r_mis;

endmodule

`default_nettype wire
